// File: rtl/mac_dot_engine.sv
// mac_dot_engine: multi-lane unsigned dot-product MAC; results leave on a valid/ready port.
// Optional build macro MAC_SAT_EN: clamp the accumulator on overflow instead of wrapping.
module mac_dot_engine #(
    parameter int DATA_W = 8,
    parameter int LANES  = 2,
    parameter int ACC_W  = 24
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] in_a,
    input  logic [LANES*DATA_W-1:0] in_b,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACC_W-1:0]        out_data,
    output logic                    out_ovf
);

    localparam int PSUM_W = 2*DATA_W + $clog2(LANES);

    generate
        if (ACC_W < PSUM_W) begin : g_acc_w_check
            $error("mac_dot_engine: ACC_W must be >= 2*DATA_W + clog2(LANES)");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

    state_t                    r_state;
    logic                      r_in_valid;
    logic                      r_in_last;
    logic [LANES*DATA_W-1:0]   r_a;
    logic [LANES*DATA_W-1:0]   r_b;
    logic                      r_p1_valid;
    logic                      r_p1_last;
    logic [PSUM_W-1:0]         r_psum;
    logic [ACC_W-1:0]          r_acc;
    logic                      r_ovf;
    logic                      r_out_valid;

    logic                      w_stall;
    logic [2*DATA_W-1:0]       w_prod [LANES];
    logic [PSUM_W-1:0]         w_psum;
    logic [ACC_W:0]            w_sum;
    logic                      w_carry;
    logic [ACC_W-1:0]          w_fold;
    logic [ACC_W-1:0]          w_start;

    // A presented result that is not taken freezes the whole pipeline.
    assign w_stall   = r_out_valid && !out_ready;
    assign in_ready  = !w_stall;
    assign out_valid = r_out_valid;
    assign out_data  = r_acc;
    assign out_ovf   = r_ovf;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign w_prod[gi] = {{DATA_W{1'b0}}, r_a[gi*DATA_W +: DATA_W]}
                              * {{DATA_W{1'b0}}, r_b[gi*DATA_W +: DATA_W]};
        end
    endgenerate

    always_comb begin
        w_psum = '0;
        for (int k = 0; k < LANES; k++) begin
            w_psum = w_psum + PSUM_W'(w_prod[k]);
        end
    end

    assign w_sum   = {1'b0, r_acc} + (ACC_W+1)'(r_psum);
    assign w_carry = w_sum[ACC_W];
    assign w_start = ACC_W'(r_psum);

`ifdef MAC_SAT_EN
    // Once clamped, the accumulator stays at full scale until the group ends.
    assign w_fold = (w_carry || r_ovf) ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
    assign w_fold = w_sum[ACC_W-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_in_valid  <= 1'b0;
            r_in_last   <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_p1_valid  <= 1'b0;
            r_p1_last   <= 1'b0;
            r_psum      <= '0;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (!w_stall) begin
            r_in_valid <= in_valid;
            if (in_valid) begin
                r_a       <= in_a;
                r_b       <= in_b;
                r_in_last <= in_last;
            end

            r_p1_valid <= r_in_valid;
            if (r_in_valid) begin
                r_psum    <= w_psum;
                r_p1_last <= r_in_last;
            end

            case (r_state)
                S_IDLE: begin
                    if (r_p1_valid) begin
                        r_acc       <= w_start;
                        r_ovf       <= 1'b0;
                        r_state     <= r_p1_last ? S_DONE : S_ACCUM;
                        r_out_valid <= r_p1_last;
                    end
                end
                S_ACCUM: begin
                    if (r_p1_valid) begin
                        r_acc <= w_fold;
                        r_ovf <= r_ovf | w_carry;
                        if (r_p1_last) begin
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    // Not stalled here means the result is being taken this cycle.
                    if (r_p1_valid) begin
                        r_acc       <= w_start;
                        r_ovf       <= 1'b0;
                        r_state     <= r_p1_last ? S_DONE : S_ACCUM;
                        r_out_valid <= r_p1_last;
                    end else begin
                        r_acc       <= '0;
                        r_ovf       <= 1'b0;
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
